debounce_multi: RTL and testbench

//   Parametrised multi-channel debouncer: successor to the single-bit debounce for PS/2 clk/data lines and board buttons.

---
 rtl/debounce_multi.sv | 97 +++++++++
 tb/tb_debounce_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser plus tick-gated saturating stability counter.
// Define DEBOUNCE_MULTI_EDGE_EN to add registered rise/fall pulse outputs.
module debounce_multi #(
  parameter int                  CHANNELS    = 4,
  parameter int                  CYCLES      = 16,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] RESET_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] changed,
`ifdef DEBOUNCE_MULTI_EDGE_EN
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
`endif
  output logic                busy
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [CHANNELS-1:0] diff;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [CNT_W-1:0]       cnt_reg;
      logic                   out_reg;
      logic                   chg_reg;
      logic                   s;

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= {SYNC_STAGES{RESET_VAL[gi]}};
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in[gi]};
        end
      end

      // Any agreeing sample clears the window; disagreement only advances on a tick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
          out_reg <= RESET_VAL[gi];
          chg_reg <= 1'b0;
        end else begin
          chg_reg <= 1'b0;
          if (s == out_reg) begin
            cnt_reg <= '0;
          end else if (tick) begin
            if (cnt_reg == CNT_LAST) begin
              out_reg <= s;
              cnt_reg <= '0;
              chg_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
      end

`ifdef DEBOUNCE_MULTI_EDGE_EN
      logic rise_reg;
      logic fall_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (s != out_reg && tick && cnt_reg == CNT_LAST) begin
            rise_reg <= s;
            fall_reg <= ~s;
          end
        end
      end

      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;
`endif

      assign sig_out[gi] = out_reg;
      assign changed[gi] = chg_reg;
      assign diff[gi]    = s ^ out_reg;
    end
  endgenerate

  assign busy = |diff;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (CHANNELS=4, CYCLES=16, SYNC_STAGES=2).
module tb_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] sig_in;
  logic [3:0] sig_out;
  logic [3:0] changed;
  logic       busy;
`ifdef DEBOUNCE_MULTI_EDGE_EN
  logic [3:0] rise;
  logic [3:0] fall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  debounce_multi #(
    .CHANNELS(4), .CYCLES(16), .SYNC_STAGES(2), .RESET_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .sig_in(sig_in),
    .sig_out(sig_out),
    .changed(changed),
`ifdef DEBOUNCE_MULTI_EDGE_EN
    .rise(rise),
    .fall(fall),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one posedge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    tick   = 1'b1;
    sig_in = 4'b0000;
    repeat (3) step();
    n_cmp++;
    if (sig_out !== 4'b0000) begin n_err++; $display("FAIL reset_sig_out got=%b exp=0000", sig_out); end
    n_cmp++;
    if (changed !== 4'b0000) begin n_err++; $display("FAIL reset_changed got=%b exp=0000", changed); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_glitch_sweep();
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 16; k++) begin
        sig_in[0] = (k < i);
        step();
        n_cmp++;
        if (sig_out[0] !== 1'b0 || changed !== 4'b0000) begin
          n_err++; bad++;
          $display("FAIL glitch_sweep i=%0d k=%0d sig_out=%b changed=%b exp sig_out[0]=0 changed=0000",
                   i, k, sig_out, changed);
        end
      end
    end
    sig_in[0] = 1'b0;
    repeat (4) step();
    $display("test_glitch_sweep done bad=%0d", bad);
  endtask

  task automatic test_clean_edge();
    sig_in[0] = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      step();
      n_cmp++;
      if (sig_out[0] !== (n >= 18)) begin
        n_err++; $display("FAIL clean_edge_out n=%0d got=%b exp=%b", n, sig_out[0], (n >= 18));
      end
      n_cmp++;
      if (changed !== ((n == 18) ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL clean_edge_changed n=%0d got=%b exp=%b", n, changed,
                          ((n == 18) ? 4'b0001 : 4'b0000));
      end
      n_cmp++;
      if (busy !== (n >= 2 && n < 18)) begin
        n_err++; $display("FAIL clean_edge_busy n=%0d got=%b exp=%b", n, busy, (n >= 2 && n < 18));
      end
`ifdef DEBOUNCE_MULTI_EDGE_EN
      n_cmp++;
      if (rise !== ((n == 18) ? 4'b0001 : 4'b0000) || fall !== 4'b0000) begin
        n_err++; $display("FAIL clean_edge_rise n=%0d rise=%b fall=%b", n, rise, fall);
      end
`endif
    end
    step();
    n_cmp++;
    if (sig_out[0] !== 1'b1 || changed !== 4'b0000) begin
      n_err++; $display("FAIL clean_edge_after sig_out=%b changed=%b exp sig_out[0]=1 changed=0000",
                        sig_out, changed);
    end
    $display("test_clean_edge done");
  endtask

  task automatic test_release_sweep();
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < w + 16; k++) begin
        sig_in[0] = (k >= w);
        step();
        n_cmp++;
        if (sig_out[0] !== 1'b1 || changed !== 4'b0000) begin
          n_err++; $display("FAIL release_sweep w=%0d k=%0d sig_out=%b changed=%b exp sig_out[0]=1",
                            w, k, sig_out, changed);
        end
      end
    end
    sig_in[0] = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      step();
      n_cmp++;
      if (sig_out[0] !== (n < 18)) begin
        n_err++; $display("FAIL release_hold n=%0d got=%b exp=%b", n, sig_out[0], (n < 18));
      end
      n_cmp++;
      if (changed[0] !== (n == 18)) begin
        n_err++; $display("FAIL release_changed n=%0d got=%b exp=%b", n, changed[0], (n == 18));
      end
`ifdef DEBOUNCE_MULTI_EDGE_EN
      n_cmp++;
      if (fall !== ((n == 18) ? 4'b0001 : 4'b0000) || rise !== 4'b0000) begin
        n_err++; $display("FAIL release_fall n=%0d fall=%b rise=%b", n, fall, rise);
      end
`endif
    end
    $display("test_release_sweep done");
  endtask

  // Ticks on every 4th posedge; a 1-clk low glitch at posedge 30 clears the 7 ticks counted
  // so far, so the 16th tick after restart lands on posedge 96.
  task automatic test_tick_gating();
    for (int p = 1; p <= 96; p++) begin
      tick      = (p % 4 == 0);
      sig_in[1] = (p != 30);
      step();
      n_cmp++;
      if (sig_out[1] !== (p >= 96)) begin
        n_err++; $display("FAIL tick_gating_out p=%0d got=%b exp=%b", p, sig_out[1], (p >= 96));
      end
      n_cmp++;
      if (changed[1] !== (p == 96)) begin
        n_err++; $display("FAIL tick_gating_changed p=%0d got=%b exp=%b", p, changed[1], (p == 96));
      end
    end
    tick = 1'b1;
    $display("test_tick_gating done");
  endtask

  task automatic test_simultaneous();
    sig_in = 4'b0000;
    repeat (20) step();
    n_cmp++;
    if (sig_out !== 4'b0000) begin n_err++; $display("FAIL simul_pre got=%b exp=0000", sig_out); end
    for (int n = 1; n <= 18; n++) begin
      sig_in = {2'b11, 1'b0, (n >= 3 && n <= 10)};
      step();
      n_cmp++;
      if (sig_out !== ((n >= 18) ? 4'b1100 : 4'b0000)) begin
        n_err++; $display("FAIL simul_out n=%0d got=%b exp=%b", n, sig_out,
                          ((n >= 18) ? 4'b1100 : 4'b0000));
      end
      n_cmp++;
      if (changed !== ((n == 18) ? 4'b1100 : 4'b0000)) begin
        n_err++; $display("FAIL simul_changed n=%0d got=%b exp=%b", n, changed,
                          ((n == 18) ? 4'b1100 : 4'b0000));
      end
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || changed !== 4'b0000) begin
      n_err++; $display("FAIL simul_after busy=%b changed=%b exp busy=0 changed=0000", busy, changed);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_count();
    sig_in = 4'b1101;
    repeat (10) step();
    n_cmp++;
    if (sig_out !== 4'b1100) begin n_err++; $display("FAIL midrst_pre got=%b exp=1100", sig_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sig_out !== 4'b0000) begin n_err++; $display("FAIL midrst_async got=%b exp=0000", sig_out); end
    repeat (3) step();
    n_cmp++;
    if (sig_out !== 4'b0000 || changed !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_hold sig_out=%b changed=%b busy=%b exp all 0", sig_out, changed, busy);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      step();
      n_cmp++;
      if (sig_out !== ((n >= 18) ? 4'b1101 : 4'b0000)) begin
        n_err++; $display("FAIL midrst_recover n=%0d got=%b exp=%b", n, sig_out,
                          ((n >= 18) ? 4'b1101 : 4'b0000));
      end
    end
    $display("test_reset_mid_count done");
  endtask

  initial begin
    test_reset();
    test_glitch_sweep();
    test_clean_edge();
    test_release_sweep();
    test_tick_gating();
    test_simultaneous();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
